// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 register file with write-through bypass,
// control decode, load-use hazard detection, jump redirect and the ID/EX
// pipeline register. A one-bit squash flag marks the instruction that fetch
// latched on a jump or taken-branch edge as wrong-path.
//
// Handshake: stall is a combinational hold request to fetch. While it is high,
// fetch keeps PC and IF/ID unchanged and this stage latches a bubble. jump is a
// combinational redirect that fetch consumes on the same edge.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        branch,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        jump,
  output logic [31:0] jump_destination,
  output logic        stall,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_A,
  output logic [31:0] ID_EX_B,
  output logic [31:0] ID_EX_Imm,
  output logic [4:0]  ID_EX_rs,
  output logic [4:0]  ID_EX_rt,
  output logic [4:0]  ID_EX_rd,
  output logic        ID_EX_RegDst,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemToReg,
  output logic        ID_EX_Branch,
  output logic [1:0]  ID_EX_ALUOp
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = IF_ID_IR[31:26];
  assign rs     = IF_ID_IR[25:21];
  assign rt     = IF_ID_IR[20:16];
  assign rd     = IF_ID_IR[15:11];
  assign imm    = IF_ID_IR[15:0];
  assign target = IF_ID_IR[25:0];

  // Register file storage; entry 0 is never written and reads are forced to 0
  logic [31:0] regs [0:31];
  logic [31:0] read_a, read_b;

  // Wrong-path marker for the instruction currently in IF/ID
  logic squash;

  // Decoded control for the current instruction
  logic       dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
  logic       dec_reg_write, dec_mem_to_reg, dec_branch, dec_is_j;
  logic       dec_uses_rs, dec_uses_rt;
  logic [1:0] dec_alu_op;

  logic load_use;
  logic bubble;

  // Register file write port: r0 stays zero, all entries clear on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Combinational reads with same-cycle writeback bypass
  always_comb begin
    read_a = regs[rs];
    read_b = regs[rt];
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs)) read_a = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rt)) read_b = wb_data;
    if (rs == 5'd0) read_a = '0;
    if (rt == 5'd0) read_b = '0;
  end

  // Opcode decode into control bits and source-register usage
  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_is_j       = 1'b0;
    dec_uses_rs    = 1'b0;
    dec_uses_rt    = 1'b0;
    dec_alu_op     = 2'b00;
    case (op)
      OP_RTYPE: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
        dec_uses_rs   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_uses_rs    = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_uses_rs   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        dec_branch  = 1'b1;
        dec_alu_op  = 2'b01;
        dec_uses_rs = 1'b1;
        dec_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_uses_rs   = 1'b1;
      end
      OP_J: begin
        dec_is_j = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use detection against the load currently in EX; branch and squash mask it
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
               ((dec_uses_rs && (ID_EX_rt == rs)) ||
                (dec_uses_rt && (ID_EX_rt == rt)));
    stall    = load_use && !branch && !squash;
    jump     = dec_is_j && !branch && !squash;
    bubble   = branch || squash || load_use;
  end

  assign jump_destination = {IF_ID_NPC[31:26], target};

  // Squash flag: the instruction fetched on a redirect edge is wrong-path
  always_ff @(posedge clk) begin
    if (!rst_n) squash <= 1'b0;
    else        squash <= jump || branch;
  end

  // ID/EX pipeline register; control bits zeroed for a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ID_EX_NPC      <= '0;
      ID_EX_A        <= '0;
      ID_EX_B        <= '0;
      ID_EX_Imm      <= '0;
      ID_EX_rs       <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd       <= '0;
      ID_EX_RegDst   <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemToReg <= 1'b0;
      ID_EX_Branch   <= 1'b0;
      ID_EX_ALUOp    <= 2'b00;
    end else begin
      ID_EX_NPC      <= IF_ID_NPC;
      ID_EX_A        <= read_a;
      ID_EX_B        <= read_b;
      ID_EX_Imm      <= {{16{imm[15]}}, imm};
      ID_EX_rs       <= rs;
      ID_EX_rt       <= rt;
      ID_EX_rd       <= rd;
      ID_EX_RegDst   <= dec_reg_dst    && !bubble;
      ID_EX_ALUSrc   <= dec_alu_src    && !bubble;
      ID_EX_MemRead  <= dec_mem_read   && !bubble;
      ID_EX_MemWrite <= dec_mem_write  && !bubble;
      ID_EX_RegWrite <= dec_reg_write  && !bubble;
      ID_EX_MemToReg <= dec_mem_to_reg && !bubble;
      ID_EX_Branch   <= dec_branch     && !bubble;
      ID_EX_ALUOp    <= bubble ? 2'b00 : dec_alu_op;
    end
  end

endmodule
